// File: rtl/pattern_gen.sv
// pattern_gen: video test-pattern generator for an RGB565 panel.
// Takes the timing stream (syncs, data enables and pixel coordinates) and
// drives it back out one clock later with a colour pattern.
// Patterns: BARS, CHECKER, HGRAD, GRID and SOLID.
// A pattern change is requested with i_next and only takes effect on a frame
// tick (falling edge of i_vsync), so a frame is never split.
// Optional feature: define PATTERN_GEN_AUTOCYCLE_EN to step the pattern
// automatically every FRAMES_PER_PATTERN frames.
`timescale 1ns/1ps
module pattern_gen #(
  parameter int H_ACTIVE           = 480,
  parameter int V_ACTIVE           = 272,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_hde,
  input  logic       i_vde,
  input  logic [8:0] i_x,
  input  logic [8:0] i_y,
  input  logic       i_next,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output logic [4:0] o_r,
  output logic [5:0] o_g,
  output logic [4:0] o_b,
  output logic [2:0] o_pattern
);

  localparam logic [2:0] PAT_BARS    = 3'd0;
  localparam logic [2:0] PAT_CHECKER = 3'd1;
  localparam logic [2:0] PAT_HGRAD   = 3'd2;
  localparam logic [2:0] PAT_GRID    = 3'd3;
  localparam logic [2:0] PAT_SOLID   = 3'd4;

  localparam logic [8:0] BAR_W  = 9'(H_ACTIVE / 8);
  localparam logic [8:0] X_LAST = 9'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLACK = 16'h0000;

  // SOLID wraps to BARS; the unused codes 5-7 also recover to BARS.
  function automatic logic [2:0] next_pattern(input logic [2:0] p);
    return (p >= PAT_SOLID) ? PAT_BARS : p + 3'd1;
  endfunction

  function automatic logic [15:0] rgb565(input logic [4:0] r, input logic [5:0] g,
                                         input logic [4:0] b);
    return {r, g, b};
  endfunction

  logic [2:0]  pattern_q, pattern_d;
  logic        pending_q, pending_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic        frame_tick;
  logic        manual_adv;
  logic        auto_adv;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [15:0] rgb_q, rgb_d;
  logic [15:0] pix;
  logic [8:0]  bar;

  assign frame_tick = vsync_prev_q & ~i_vsync;
  assign manual_adv = frame_tick & (pending_q | i_next);

`ifdef PATTERN_GEN_AUTOCYCLE_EN
  localparam int CNT_W = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign auto_adv = frame_tick & (frame_cnt_q == CNT_LAST);

  // Frames shown in the current pattern; any advance restarts the count.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_tick)
      frame_cnt_d = (manual_adv | auto_adv) ? '0 : frame_cnt_q + CNT_W'(1);
  end

  // Frame counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) frame_cnt_q <= '0;
    else          frame_cnt_q <= frame_cnt_d;
  end
`else
  assign auto_adv = 1'b0;
`endif

  // Pattern state register with pending request and previous vsync sample.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pattern_q    <= PAT_BARS;
      pending_q    <= 1'b0;
      vsync_prev_q <= 1'b1;
    end else begin
      pattern_q    <= pattern_d;
      pending_q    <= pending_d;
      vsync_prev_q <= vsync_prev_d;
    end
  end

  // Next state: requests accumulate during a frame and collapse into one step.
  always_comb begin
    pattern_d    = pattern_q;
    pending_d    = pending_q | i_next;
    vsync_prev_d = i_vsync;
    if (frame_tick) begin
      pending_d = 1'b0;
      if (manual_adv | auto_adv) pattern_d = next_pattern(pattern_q);
    end
  end

  // Pixel colour for the current coordinates in the current pattern.
  always_comb begin
    pix = BLACK;
    bar = i_x / BAR_W;
    case (pattern_q)
      PAT_BARS: begin
        if ({1'b0, i_x} < 10'(H_ACTIVE)) begin
          case (bar)
            9'd0:    pix = WHITE;
            9'd1:    pix = rgb565(5'd31, 6'd63, 5'd0);
            9'd2:    pix = rgb565(5'd0, 6'd63, 5'd31);
            9'd3:    pix = rgb565(5'd0, 6'd63, 5'd0);
            9'd4:    pix = rgb565(5'd31, 6'd0, 5'd31);
            9'd5:    pix = rgb565(5'd31, 6'd0, 5'd0);
            9'd6:    pix = rgb565(5'd0, 6'd0, 5'd31);
            default: pix = BLACK;
          endcase
        end
      end
      PAT_CHECKER: pix = (i_x[4] ^ i_y[4]) ? WHITE : BLACK;
      PAT_HGRAD:   pix = rgb565(i_x[8:4], i_x[8:3], i_x[8:4]);
      PAT_GRID:    pix = ((i_x[3:0] == 4'd0) || (i_y[3:0] == 4'd0) ||
                          (i_x == X_LAST) || (i_y == Y_LAST)) ? WHITE : BLACK;
      PAT_SOLID:   pix = WHITE;
      default:     pix = BLACK;
    endcase
  end

  // Output stage inputs: colour is blanked whenever the delayed DE will be low.
  always_comb begin
    hsync_d = i_hsync;
    vsync_d = i_vsync;
    de_d    = i_hde & i_vde;
    rgb_d   = de_d ? pix : BLACK;
  end

  // Single output register stage keeps syncs, DE and colour aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= BLACK;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
    end
  end

  assign o_hsync   = hsync_q;
  assign o_vsync   = vsync_q;
  assign o_de      = de_q;
  assign o_r       = rgb_q[15:11];
  assign o_g       = rgb_q[10:5];
  assign o_b       = rgb_q[4:0];
  assign o_pattern = pattern_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Testbench for pattern_gen: directed steps plus random timing traffic, all
// checked against a behavioural model of the pattern rules.
`timescale 1ns/1ps
module tb_pattern_gen;

  localparam int H   = 480;
  localparam int V   = 272;
  localparam int FPP = 2;
`ifdef PATTERN_GEN_AUTOCYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, hs, vs, hde, vde, nxt;
  logic [8:0] x, y;
  logic       o_hs, o_vs, o_de;
  logic [4:0] o_r, o_b;
  logic [5:0] o_g;
  logic [2:0] o_pat;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_pat;
  int m_cnt;
  bit m_pend;
  bit m_vprev;

  always #5 clk = ~clk;

  pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .FRAMES_PER_PATTERN(FPP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hs), .i_vsync(vs), .i_hde(hde),
    .i_vde(vde), .i_x(x), .i_y(y), .i_next(nxt), .o_hsync(o_hs), .o_vsync(o_vs),
    .o_de(o_de), .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_pattern(o_pat)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack(input int r, input int g, input int b);
    logic [4:0] rr; logic [5:0] gg; logic [4:0] bb;
    rr = 5'(r); gg = 6'(g); bb = 5'(b);
    return {rr, gg, bb};
  endfunction

  function automatic logic [15:0] bar_colour(input int i);
    case (i)
      0: return pack(31, 63, 31);
      1: return pack(31, 63, 0);
      2: return pack(0, 63, 31);
      3: return pack(0, 63, 0);
      4: return pack(31, 0, 31);
      5: return pack(31, 0, 0);
      6: return pack(0, 0, 31);
      default: return pack(0, 0, 0);
    endcase
  endfunction

  function automatic logic [15:0] ref_colour(input int p, input int xx, input int yy);
    logic [15:0] white;
    white = pack(31, 63, 31);
    case (p)
      0: return (xx >= H) ? 16'h0 : bar_colour(xx / (H / 8));
      1: return (((xx / 16) + (yy / 16)) % 2 == 1) ? white : 16'h0;
      2: return pack(xx / 16, xx / 8, xx / 16);
      3: return ((xx % 16 == 0) || (yy % 16 == 0) || (xx == H - 1) || (yy == V - 1))
                ? white : 16'h0;
      default: return white;
    endcase
  endfunction

  task automatic model_reset();
    m_pat = 0; m_cnt = 0; m_pend = 0; m_vprev = 1;
  endtask

  // Apply current inputs across one clock edge, advance the model, check all outputs.
  task automatic cycle();
    logic [15:0] exp_rgb;
    bit exp_hs, exp_vs, exp_de, tick, adv;
    exp_hs  = hs;
    exp_vs  = vs;
    exp_de  = hde & vde;
    exp_rgb = exp_de ? ref_colour(m_pat, int'(x), int'(y)) : 16'h0;
    tick    = m_vprev && !vs;
    if (tick) begin
      adv = m_pend || nxt;
      if (AUTO && m_cnt == FPP - 1) adv = 1;
      if (adv) begin
        m_pat = (m_pat + 1) % 5;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_pend = 0;
    end else begin
      m_pend = m_pend || nxt;
    end
    m_vprev = vs;
    @(posedge clk); #1;
    chk("hsync", o_hs, exp_hs);
    chk("vsync", o_vs, exp_vs);
    chk("de", o_de, exp_de);
    chk("rgb", {o_r, o_g, o_b}, exp_rgb);
    chk("pattern", o_pat, m_pat);
  endtask

  task automatic pix(input int xx, input int yy);
    x = 9'(xx); y = 9'(yy); hde = 1; vde = 1; nxt = 0;
    cycle();
  endtask

  task automatic advance_to(input int p);
    for (int i = 0; i < 12 && m_pat != p; i++) begin
      nxt = 1; vs = 1; cycle();
      nxt = 0; vs = 0; cycle();
      vs = 1; cycle();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hsync"}, o_hs, 1);
    chk({tag, "_vsync"}, o_vs, 1);
    chk({tag, "_de"}, o_de, 0);
    chk({tag, "_rgb"}, {o_r, o_g, o_b}, 0);
    chk({tag, "_pattern"}, o_pat, 0);
  endtask

  initial begin
    rst_n = 0; hs = 1; vs = 1; hde = 0; vde = 0; x = 0; y = 0; nxt = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1;
    @(posedge clk); #1;

    // Colour bars at the bar boundaries and past the active width
    pix(0, 10);   chk("bars_x0",   {o_r, o_g, o_b}, pack(31, 63, 31));
    pix(59, 10);  chk("bars_x59",  {o_r, o_g, o_b}, pack(31, 63, 31));
    pix(60, 10);  chk("bars_x60",  {o_r, o_g, o_b}, pack(31, 63, 0));
    pix(479, 10); chk("bars_x479", {o_r, o_g, o_b}, pack(0, 0, 0));
    pix(500, 10); chk("bars_clamp", {o_r, o_g, o_b}, pack(0, 0, 0));

    // Reset mid-line with DE high, after building a pending request
    nxt = 1; cycle(); nxt = 0;
    x = 100; hde = 1; vde = 1; hs = 0;
    rst_n = 0; #1;
    model_reset();
    check_reset_outputs("midline");
    @(posedge clk); #1;
    check_reset_outputs("held");
    rst_n = 1; hs = 1;
    pix(60, 20); chk("post_rst_bars", {o_r, o_g, o_b}, pack(31, 63, 0));
    vs = 0; pix(0, 0); chk("pend_discarded", o_pat, 0);
    vs = 1; pix(0, 0);

    // Several requests in one frame collapse into one advance
    for (int i = 0; i < 3; i++) begin
      nxt = 1; cycle(); nxt = 0; cycle();
    end
    chk("hold_until_tick", o_pat, 0);
    vs = 0; cycle(); chk("one_advance", o_pat, 1);
    vs = 1; cycle(); chk("no_double", o_pat, 1);
    vs = 0; nxt = 1; cycle(); chk("coincident_next", o_pat, 2);
    nxt = 0; vs = 1; cycle();

    // CHECKER, HGRAD and GRID sample points
    advance_to(1);
    pix(16, 0);  chk("checker_16_0", {o_r, o_g, o_b}, pack(31, 63, 31));
    pix(16, 16); chk("checker_16_16", {o_r, o_g, o_b}, pack(0, 0, 0));
    advance_to(2);
    pix(479, 3); chk("hgrad_479", {o_r, o_g, o_b}, pack(29, 59, 29));
    advance_to(3);
    pix(5, 271); chk("grid_5_271", {o_r, o_g, o_b}, pack(31, 63, 31));
    pix(5, 5);   chk("grid_5_5", {o_r, o_g, o_b}, pack(0, 0, 0));
    advance_to(4);
    pix(123, 45); chk("solid", {o_r, o_g, o_b}, pack(31, 63, 31));

    // DE low blanks colour in every pattern
    for (int p = 0; p < 5; p++) begin
      advance_to(p);
      x = 9'(30 + p); y = 9'(40); hde = 0; vde = 1; hs = p[0]; nxt = 0;
      cycle();
      chk("blank_de", o_de, 0);
      chk("blank_rgb", {o_r, o_g, o_b}, 0);
      hs = 1;
    end

    // Frame ticks with no requests: autocycle steps every FPP frames
    rst_n = 0; #1; model_reset();
    @(posedge clk); #1;
    rst_n = 1; vs = 1; hde = 1; vde = 1; nxt = 0;
    cycle();
    for (int k = 1; k <= 11; k++) begin
      vs = 0; cycle();
      vs = 1; cycle();
      chk("autocycle", o_pat, AUTO ? (k / FPP) % 5 : 0);
    end

    // Random timing and requests
    for (int i = 0; i < 600; i++) begin
      hs  = 1'($urandom % 2);
      vs  = ($urandom % 6) != 0;
      hde = 1'($urandom % 2);
      vde = ($urandom % 4) != 0;
      x   = 9'($urandom % 512);
      y   = 9'($urandom % 512);
      nxt = ($urandom % 12) == 0;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
PATTERN_GEN -- requirements
Module: pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 272, active lines per frame.
REQ-003 SHALL have parameter FRAMES_PER_PATTERN, default 60, frames per pattern in auto-cycle mode.
REQ-004 SHALL have ports: i_clk  in  1  pixel clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: i_hsync  in  1  active-low; i_vsync  in  1  active-low; i_hde  in  1  horizontal data enable; i_vde  in  1  vertical data enable.
REQ-006 SHALL have ports: i_x  in  9  pixel column; i_y  in  9  line number; i_next  in  1  single-cycle request to advance pattern.
REQ-007 SHALL have ports: o_hsync, o_vsync  out  1  delayed syncs; o_de  out  1  delayed i_hde & i_vde; o_r  out  5; o_g  out  6; o_b  out  5; o_pattern  out  3  current pattern index.

Function
REQ-008 SHALL register o_hsync, o_vsync, o_de, o_r, o_g, o_b; latency exactly 1 i_clk from inputs to all of them, so sync/DE/colour stay aligned.
REQ-009 SHALL drive o_r/o_g/o_b to 0 in any cycle whose registered o_de is 0.
REQ-010 SHALL detect frame tick as the falling edge of i_vsync (previous sample 1, current 0), using a registered previous sample.
REQ-011 SHALL hold a 3-bit pattern state: BARS=0, CHECKER=1, HGRAD=2, GRID=3, SOLID=4; advance = next index, 4 wraps to 0; values 5-7 unreachable and, if present, forced to 0 on the next advance.
REQ-012 SHALL latch i_next into a pending flag; pattern changes only on a frame tick, never mid-frame.
REQ-013 SHALL, on a frame tick with pending set (or i_next high in that same cycle), advance once and clear pending; several i_next pulses within one frame SHALL produce one advance.
REQ-014 BARS SHALL output 8 vertical bars, bar = i_x / (H_ACTIVE/8), colours in order white, yellow, cyan, green, magenta, red, blue, black; i_x >= H_ACTIVE SHALL clamp to black.
REQ-015 CHECKER SHALL output white when i_x[4] ^ i_y[4] is 1, else black.
REQ-016 HGRAD SHALL output r = i_x[8:4], g = i_x[8:3], b = i_x[8:4].
REQ-017 GRID SHALL output white when i_x[3:0]==0, i_y[3:0]==0, i_x==H_ACTIVE-1 or i_y==V_ACTIVE-1, else black.
REQ-018 SOLID SHALL output full white (r=31, g=63, b=31).
REQ-019 SHALL reflect the pattern state on o_pattern combinationally from the state register.

Reset
REQ-020 SHALL, on i_rst_n low, immediately set o_hsync=1, o_vsync=1, o_de=0, o_r=o_g=o_b=0, pattern=BARS, pending=0, frame counter=0, previous-vsync sample=1.
REQ-021 SHALL, after reset release, not generate a frame tick unless i_vsync actually goes 1->0.
REQ-022 SHALL discard a pending request and partial frame count when reset asserts mid-frame.

Configuration
REQ-023 SHALL use macro PATTERN_GEN_AUTOCYCLE_EN.
REQ-024 With PATTERN_GEN_AUTOCYCLE_EN defined: a frame counter (width >= clog2(FRAMES_PER_PATTERN)) increments per frame tick; on the tick where it equals FRAMES_PER_PATTERN-1, pattern advances and counter clears; a manual advance also clears the counter; coincident auto and manual advance SHALL advance once.
REQ-025 Without PATTERN_GEN_AUTOCYCLE_EN: no frame counter is synthesised; pattern changes only via i_next.

Verification
REQ-026 Reset mid-line with i_hde=i_vde=1 -> outputs at reset values same cycle; o_pattern=0; first cycle after release with de=1 shows BARS colour one clock later.
REQ-027 BARS, i_x=0,59,60,479 with de=1 -> one cycle later RGB = (31,63,31), (31,63,31), (31,63,0) yellow, (0,0,0).
REQ-028 i_next pulsed 3 times in one frame -> o_pattern stays 0 until next i_vsync fall, then 1 exactly; i_next coincident with vsync fall -> advances that cycle.
REQ-029 CHECKER, (x,y)=(16,0) -> white; (16,16) -> black; HGRAD x=479 -> (29,59,29); GRID (x,y)=(5,271) -> white, (5,5) -> black.
REQ-030 Autocycle built, FRAMES_PER_PATTERN=2 -> pattern 0,0,1,1,2,2,3,3,4,4,0 across 11 frame ticks; without macro same stimulus -> pattern remains 0.
REQ-031 de low (i_hde=0, i_vde=1) in any pattern -> o_de=0 and RGB=0 one cycle later; o_hsync/o_vsync track inputs with 1-cycle delay.
